// File: rtl/stage_scroll_if.sv
// Handshake bundle between the stage update logic and the scroll animator.
interface stage_scroll_if;
    logic             scroll_start;
    logic             frame_tick;
    logic [1:0][9:0]  stage_x;
    logic [1:0][9:0]  moved_stage_x;
    logic             move_fin;
    logic             busy;

    modport master (
        output scroll_start,
        output frame_tick,
        output stage_x,
        input  moved_stage_x,
        input  move_fin,
        input  busy
    );

    modport slave (
        input  scroll_start,
        input  frame_tick,
        input  stage_x,
        output moved_stage_x,
        output move_fin,
        output busy
    );
endinterface

// File: rtl/stage_scroll.sv
// Camera-scroll animator: slides both stages left by STEP per frame tick until
// stage 0 is back at HOME_X, then pulses move_fin with the final positions.
module stage_scroll #(
    parameter logic [9:0] HOME_X = 10'd60,
    parameter logic [9:0] STEP   = 10'd4
) (
    input  logic          clk,
    input  logic          rst,
    stage_scroll_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StMove, StDone} state_e;

    state_e     state_q, state_d;
    logic [9:0] base0_q, base0_d;
    logic [9:0] base1_q, base1_d;
    logic [9:0] total_q, total_d;
    logic [9:0] offset_q, offset_d;
    logic [9:0] moved0_q, moved0_d;
    logic [9:0] moved1_q, moved1_d;
    logic [9:0] rem;
    logic       upd;

    always_comb begin
        state_d  = state_q;
        base0_d  = base0_q;
        base1_d  = base1_q;
        total_d  = total_q;
        offset_d = offset_q;
        moved0_d = moved0_q;
        moved1_d = moved1_q;
        upd      = 1'b0;
        // offset never exceeds total, so this cannot wrap
        rem      = total_q - offset_q;

        case (state_q)
            StIdle: begin
                if (bus.scroll_start) begin
                    base0_d  = bus.stage_x[0];
                    base1_d  = bus.stage_x[1];
                    offset_d = '0;
                    total_d  = (bus.stage_x[0] > HOME_X) ? (bus.stage_x[0] - HOME_X) : '0;
                    state_d  = (total_d == '0) ? StDone : StMove;
                    upd      = 1'b1;
                end
            end
            StMove: begin
                if (bus.frame_tick) begin
                    if (rem > STEP) begin
                        offset_d = offset_q + STEP;
                    end else begin
                        offset_d = total_q;
                        state_d  = StDone;
                    end
                    upd = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs only move on a capture or a step; otherwise they hold the last value
        if (upd) begin
            moved0_d = base0_d - offset_d;
            moved1_d = (base1_d < offset_d) ? '0 : (base1_d - offset_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            base0_q  <= '0;
            base1_q  <= '0;
            total_q  <= '0;
            offset_q <= '0;
            moved0_q <= HOME_X;
            moved1_q <= '0;
        end else begin
            state_q  <= state_d;
            base0_q  <= base0_d;
            base1_q  <= base1_d;
            total_q  <= total_d;
            offset_q <= offset_d;
            moved0_q <= moved0_d;
            moved1_q <= moved1_d;
        end
    end

    assign bus.move_fin         = (state_q == StDone);
    assign bus.busy             = (state_q != StIdle);
    assign bus.moved_stage_x[0] = moved0_q;
    assign bus.moved_stage_x[1] = moved1_q;

endmodule

// File: tb/tb_stage_scroll.sv
// Directed bench for stage_scroll with a queue of expected final positions.
module tb_stage_scroll;

    localparam int HOME = 60;
    localparam int STP  = 4;
    localparam int GAP  = 10;

    typedef struct {
        int f0;
        int f1;
        int nticks;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   ticks_seen = 0;
    int   fin_count = 0;
    logic prev_fin = 1'b0;
    exp_t q[$];

    stage_scroll_if bus();

    stage_scroll #(
        .HOME_X(10'd60),
        .STEP  (10'd4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int s0, input int s1);
        exp_t e;
        int   total;
        total    = (s0 > HOME) ? s0 - HOME : 0;
        e.nticks = (total + STP - 1) / STP;
        e.f0     = s0 - total;
        e.f1     = (s1 > total) ? s1 - total : 0;
        return e;
    endfunction

    task automatic do_tick();
        repeat (GAP - 1) cyc();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        ticks_seen++;
    endtask

    // intrude_at >= 0 injects an ignored second start before that tick index
    task automatic run_scroll(input int s0, input int s1, input int intrude_at, input bit tick_w_start);
        exp_t e;
        int   fin_before;
        int   step1;
        e = model(s0, s1);
        q.push_back(e);
        fin_before       = fin_count;
        ticks_seen       = 0;
        bus.stage_x[0]   = 10'(s0);
        bus.stage_x[1]   = 10'(s1);
        bus.scroll_start = 1'b1;
        bus.frame_tick   = tick_w_start;
        cyc();
        bus.scroll_start = 1'b0;
        bus.frame_tick   = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("cap0", 32'(bus.moved_stage_x[0]), 32'(s0));
        check("cap1", 32'(bus.moved_stage_x[1]), 32'(s1));
        check("fin_at_start", 32'(bus.move_fin), 32'(e.nticks == 0));
        for (int i = 0; i < e.nticks; i++) begin
            if (i == intrude_at) begin
                bus.stage_x[0]   = 10'd400;
                bus.stage_x[1]   = 10'd500;
                bus.scroll_start = 1'b1;
                cyc();
                bus.scroll_start = 1'b0;
            end
            do_tick();
            if (i == 0) begin
                step1 = (s0 - e.f0 < STP) ? s0 - e.f0 : STP;
                check("step1_x0", 32'(bus.moved_stage_x[0]), 32'(s0 - step1));
                check("step1_x1", 32'(bus.moved_stage_x[1]), 32'((s1 > step1) ? s1 - step1 : 0));
            end
        end
        repeat (3) cyc();
        check("fin_count", 32'(fin_count - fin_before), 32'd1);
        check("busy_end", 32'(bus.busy), 32'd0);
        check("hold0", 32'(bus.moved_stage_x[0]), 32'(e.f0));
        check("hold1", 32'(bus.moved_stage_x[1]), 32'(e.f1));
    endtask

    always @(negedge clk) begin
        if (bus.move_fin === 1'b1) begin
            exp_t e;
            fin_count++;
            check("fin_width", 32'(prev_fin), 32'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL fin_unexpected: observed move_fin 1 expected 0");
            end else begin
                e = q.pop_front();
                check("final0", 32'(bus.moved_stage_x[0]), 32'(e.f0));
                check("final1", 32'(bus.moved_stage_x[1]), 32'(e.f1));
                check("nticks", 32'(ticks_seen), 32'(e.nticks));
            end
        end
        prev_fin = bus.move_fin;
    end

    initial begin
        int fin_before;
        rst              = 1'b1;
        bus.scroll_start = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.stage_x[0]   = '0;
        bus.stage_x[1]   = '0;
        repeat (2) cyc();
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_fin", 32'(bus.move_fin), 32'd0);
        check("rst_x0", 32'(bus.moved_stage_x[0]), 32'd60);
        check("rst_x1", 32'(bus.moved_stage_x[1]), 32'd0);

        run_scroll(200, 320, -1, 1'b0);
        run_scroll(203, 250, -1, 1'b0);
        run_scroll(60, 150, -1, 1'b0);
        run_scroll(40, 150, -1, 1'b0);
        run_scroll(200, 320, 5, 1'b0);
        run_scroll(300, 100, -1, 1'b1);

        // Reset partway through a 35-tick scroll
        fin_before       = fin_count;
        bus.stage_x[0]   = 10'd200;
        bus.stage_x[1]   = 10'd320;
        bus.scroll_start = 1'b1;
        cyc();
        bus.scroll_start = 1'b0;
        repeat (10) do_tick();
        check("mid_x0", 32'(bus.moved_stage_x[0]), 32'd160);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_x0", 32'(bus.moved_stage_x[0]), 32'd60);
        check("rst_mid_x1", 32'(bus.moved_stage_x[1]), 32'd0);
        repeat (5) do_tick();
        check("rst_mid_nofin", 32'(fin_count - fin_before), 32'd0);
        check("rst_mid_idle", 32'(bus.busy), 32'd0);

        run_scroll(200, 320, -1, 1'b0);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
